// File: rtl/product_accumulator_if.sv
// ============================================================================
// Module   : product_accumulator_if
// Purpose  : Product stream in from the multiplier and group-sum stream out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface product_accumulator_if #(
    parameter int ACC_W = 72
);
    logic             mult_en;
    logic [63:0]      prod_in;
    logic             prod_valid;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output mult_en, prod_in, prod_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  mult_en, prod_in, prod_valid, out_ready,
        output out_data, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// Module   : product_accumulator
// Purpose  : Sums GROUP signed products into a wide accumulator and queues
//            each group sum in a small valid/ready FIFO.
//            Optional macro PRODUCT_ACC_SAT_EN selects saturating addition.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator #(
    parameter int GROUP = 4,
    parameter int ACC_W = 72,
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    product_accumulator_if.slave        bus,
    input  wire logic                   clear,
    output logic [7:0]                  grp_count,
    output logic                        overflow,
    output logic                        sat_flag
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [c_PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [ACC_W-1:0]        mem_q [DEPTH];
    logic [ACC_W-1:0]        mem_d [DEPTH];
    logic [ACC_W-1:0]        out_data_q, out_data_d;
    logic                    ovf_q, ovf_d;

    logic                    w_accept;
    logic                    w_complete;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;

    // Multiplier strobes with garbage data while disabled, so mult_en gates everything.
    assign w_accept   = bus.prod_valid & bus.mult_en;
    assign w_prod_ext = ACC_W'($signed(bus.prod_in));
    assign w_base     = clear ? '0 : acc_q;

    // A clear collision restarts the group, so only GROUP=1 can complete on it.
    assign w_complete = w_accept &&
                        ((GROUP == 1) || (!clear && (cnt_q == 8'(GROUP - 1))));

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_PTR_W] != rd_ptr_q[c_PTR_W]) &&
                     (wr_ptr_q[c_PTR_W-1:0] == rd_ptr_q[c_PTR_W-1:0]);
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_push  = w_complete && (!w_full || w_pop);

`ifdef PRODUCT_ACC_SAT_EN
    logic signed [ACC_W:0] w_wide;
    logic                  w_clamp;
    logic                  sat_q, sat_d;

    assign w_wide  = {w_base[ACC_W-1], w_base} + {w_prod_ext[ACC_W-1], w_prod_ext};
    assign w_clamp = (w_wide[ACC_W] != w_wide[ACC_W-1]);
    assign w_sum   = !w_clamp        ? w_wide[ACC_W-1:0] :
                     w_wide[ACC_W]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                                       {1'b0, {(ACC_W-1){1'b1}}};
    assign sat_d   = sat_q | (w_accept & w_clamp);
    assign sat_flag = sat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    assign w_sum    = w_base + w_prod_ext;
    assign sat_flag = 1'b0;
`endif

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        ovf_d    = ovf_q;

        if (w_accept) begin
            if (w_complete) begin
                acc_d = '0;
                cnt_d = 8'd0;
            end else begin
                acc_d = w_sum;
                cnt_d = clear ? 8'd1 : cnt_q + 8'd1;
            end
        end else if (clear) begin
            acc_d = '0;
            cnt_d = 8'd0;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // On full+pop the write slot is the head being popped, so overwriting is safe.
        if (w_push) begin
            mem_d[wr_ptr_q[c_PTR_W-1:0]] = w_sum;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_complete && !w_push) begin
            ovf_d = 1'b1;
        end

        // Registered head view; holds the last shown word once the FIFO drains.
        out_data_d = (wr_ptr_d != rd_ptr_d) ? mem_d[rd_ptr_d[c_PTR_W-1:0]] : out_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            cnt_q      <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is only ever read after being written, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = !w_empty;
    assign grp_count     = cnt_q;
    assign overflow      = ovf_q;

endmodule

`default_nettype wire

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 32x32 signed sequential multiplier.
- Captures each 64-bit signed product on the multiplier's completion strobe and sums GROUP consecutive products into a wide signed accumulator.
- Pushes each completed group sum into a small output FIFO, drained through a valid/ready handshake.
- Forms the accumulate half of the team's sequential MAC datapath.

Parameters:
- GROUP, 4: products summed per output word; legal range 1..255.
- ACC_W, 72: accumulator and output width; must be at least 64.
- DEPTH, 4: output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- mult_en  in  1  multiplier enable; qualifies prod_valid
- prod_in  in  64  signed product from the multiplier's result output
- prod_valid  in  1  multiplier completion strobe (enableOutput)
- clear  in  1  synchronous abort of the current partial group
- out_data  out  ACC_W  signed group sum at the FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data
- grp_count  out  8  products accumulated in the current group
- overflow  out  1  sticky: a completed group was dropped because the FIFO was full
- sat_flag  out  1  sticky saturation indicator (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): accumulator=0, grp_count=0, FIFO emptied, out_valid=0, out_data=0, overflow=0, sat_flag=0.
- Accept: accept = prod_valid & mult_en. The multiplier raises enableOutput with X data while en=0, so prod_valid with mult_en=0 must be ignored entirely.
- Extension: prod_in is sign-extended to ACC_W before addition. Default arithmetic wraps modulo 2^ACC_W.
- Counter: on accept, next_sum = acc + sext(prod_in) and grp_count increments.
- Group completion: when accept occurs with grp_count==GROUP-1:
  - next_sum is pushed into the FIFO in the same cycle;
  - acc <= 0 and grp_count <= 0;
  - out_valid rises on the following edge if the FIFO was empty (latency 1 cycle from the completing strobe).
- GROUP=1: every accepted product is pushed as sext(prod_in).
- Group states are implicit in grp_count: EMPTY (0), PARTIAL (1..GROUP-1). EMPTY goes to PARTIAL on accept; PARTIAL goes to EMPTY on completion or clear.
- clear=1 without accept: acc <= 0, grp_count <= 0. FIFO contents and flags are unaffected.
- clear=1 with accept in the same cycle: the partial group is discarded, and the new product starts a fresh group (acc <= sext(prod_in), grp_count <= 1). If GROUP=1, the product is pushed instead.
- FIFO pop: out_valid & out_ready pops the head. out_data always shows the head entry and is held stable while out_valid=1 and out_ready=0.
- Empty: out_ready is ignored; out_data holds its last value.
- Full with push and no pop: the new sum is dropped, overflow <= 1 (sticky until reset), FIFO unchanged, and the accumulator still clears.
- Full with push and pop in the same cycle: both succeed and occupancy is unchanged.
- Pointers: log2(DEPTH)+1 bits with wrap-around. full = MSBs differ and LSBs equal; empty = pointers equal.

Optional Feature:
- Macro: PRODUCT_ACC_SAT_EN.
- Defined:
  - the accumulator add saturates to the signed ACC_W limits, +(2^(ACC_W-1)-1) or -2^(ACC_W-1), instead of wrapping;
  - any clamp sets sat_flag (sticky until reset);
  - the clamped value is what gets pushed or kept.
- Not defined: the add wraps and sat_flag is tied to 0.

Test Plan:
- Basic group: GROUP=4, mult_en=1; strobe products 3, -5, 10, 7 -> one cycle after the 4th strobe, out_valid=1 and out_data=15; grp_count reads 1, 2, 3, 0.
- Enable qualification: prod_valid=1 with mult_en=0 and prod_in=X for 3 cycles -> grp_count stays 0 and no push; a subsequent group of four 1s yields 4.
- Clear collision: after products 100 and 200, assert clear together with a strobe of product 9 -> grp_count=1; the next three products of 1 yield out_data=12.
- FIFO full/drop: out_ready=0; complete 5 groups of four 1s (DEPTH=4) -> 5th group dropped, overflow=1; drain yields four words of 4, then out_valid=0.
- Full push+pop: FIFO full; complete a group in the same cycle as out_ready=1 -> no overflow, occupancy stays 4, and the new sum appears last.
- Saturation (macro defined, ACC_W=64): products 0x7FFFFFFFFFFFFFFF and 1 -> accumulator clamps to 0x7FFFFFFFFFFFFFFF and sat_flag=1. Without the macro: wraps to 0x8000000000000000 and sat_flag=0.
- Async reset: assert reset=0 mid-group with the FIFO holding 2 entries -> immediately out_valid=0, grp_count=0, overflow=0.
